// File: rtl/clock_mode_fsm.sv
// clock_mode_fsm: debounces four active-low buttons and runs the CLOCK/SETUP/ALARM mode machine (optional MODE_TIMEOUT_EN idle return).
// Latency: a clean press yields its event DEB_CYCLES+3 cycles after the raw edge; every *_inc enable is registered 1 cycle after its cause.
// Backpressure: none; all outputs are fire-and-forget strobes or levels, and dropped same-cycle actions are never queued.
module clock_mode_fsm #(
    parameter int DEB_CYCLES = 500000,
    parameter int REPEAT_DLY = 25000000,
    parameter int REPEAT_PER = 5000000,
    parameter int TIMEOUT    = 500000000
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       i_sw0,
    input  logic       i_sw1,
    input  logic       i_sw2,
    input  logic       i_sw3,
    input  logic       i_tick_1hz,
    input  logic       i_sec_wrap,
    output logic [1:0] o_mode,
    output logic       o_position,
    output logic       o_alarm_en,
    output logic       o_sec_inc,
    output logic       o_min_inc,
    output logic       o_alm_sec_inc,
    output logic       o_alm_min_inc
);

    typedef enum logic [1:0] {
        MODE_CLOCK = 2'b00,
        MODE_SETUP = 2'b01,
        MODE_ALARM = 2'b10,
        MODE_RSVD  = 2'b11
    } mode_t;

    localparam int BTN_MODE = 0;
    localparam int BTN_POS  = 1;
    localparam int BTN_INC  = 2;
    localparam int BTN_ALM  = 3;

    localparam int DW = $clog2(DEB_CYCLES + 1);
    localparam logic [DW-1:0] DEB_LAST = DW'(DEB_CYCLES - 1);

    localparam int RMAX = (REPEAT_DLY > REPEAT_PER) ? REPEAT_DLY : REPEAT_PER;
    localparam int RW   = $clog2(RMAX + 1);
    localparam logic [RW-1:0] RPT_DLY = RW'(REPEAT_DLY);
    localparam logic [RW-1:0] RPT_PER = RW'(REPEAT_PER);

    // ------------------------------------------------------------------
    // Button input path: synchroniser, stable counter, press strobe
    // ------------------------------------------------------------------
    logic [3:0]    w_raw;
    logic [3:0]    r_sync1;
    logic [3:0]    r_sync2;
    logic [3:0]    r_deb;
    logic [3:0]    r_evt;
    logic [DW-1:0] r_deb_cnt [4];

    assign w_raw = {i_sw3, i_sw2, i_sw1, i_sw0};

    // Two-flop synchroniser; buttons idle high (released).
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_sync1 <= '1;
            r_sync2 <= '1;
        end else begin
            r_sync1 <= w_raw;
            r_sync2 <= r_sync1;
        end
    end

    // Accept a new level only after DEB_CYCLES consecutive disagreeing samples; strobe on the 1->0 flip.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_deb <= '1;
            r_evt <= '0;
            for (int b = 0; b < 4; b++) begin
                r_deb_cnt[b] <= '0;
            end
        end else begin
            for (int b = 0; b < 4; b++) begin
                r_evt[b] <= 1'b0;
                if (r_sync2[b] != r_deb[b]) begin
                    if (r_deb_cnt[b] == DEB_LAST) begin
                        r_deb[b]     <= r_sync2[b];
                        r_deb_cnt[b] <= '0;
                        r_evt[b]     <= ~r_sync2[b];
                    end else begin
                        r_deb_cnt[b] <= r_deb_cnt[b] + 1'b1;
                    end
                end else begin
                    r_deb_cnt[b] <= '0;
                end
            end
        end
    end

    // ------------------------------------------------------------------
    // sw2 auto-repeat: first repeat REPEAT_DLY after the press, then every REPEAT_PER
    // ------------------------------------------------------------------
    logic [RW-1:0] r_rpt_cnt;
    logic          r_rpt_phase;
    logic          w_rpt_hit;
    logic          w_sw2_req;

    assign w_rpt_hit = ~r_deb[BTN_INC] &
                       (r_rpt_phase ? (r_rpt_cnt == RPT_PER) : (r_rpt_cnt == RPT_DLY));
    assign w_sw2_req = r_evt[BTN_INC] | w_rpt_hit;

    // Repeat counter runs while sw2 is held (debounced) and clears on release.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_rpt_cnt   <= '0;
            r_rpt_phase <= 1'b0;
        end else if (r_deb[BTN_INC]) begin
            r_rpt_cnt   <= '0;
            r_rpt_phase <= 1'b0;
        end else if (w_rpt_hit) begin
            r_rpt_cnt   <= RW'(1);
            r_rpt_phase <= 1'b1;
        end else begin
            r_rpt_cnt   <= r_rpt_cnt + 1'b1;
        end
    end

    // ------------------------------------------------------------------
    // Mode state and registered enables
    // ------------------------------------------------------------------
    mode_t r_mode;
    mode_t w_mode_nx;
    logic  r_pos,     w_pos_nx;
    logic  r_alm,     w_alm_nx;
    logic  r_sec_inc, w_sec_nx;
    logic  r_min_inc, w_min_nx;
    logic  r_asec_inc, w_asec_nx;
    logic  r_amin_inc, w_amin_nx;
    logic  w_req;
    logic  w_timeout;

    // A mode-step event wins the cycle: same-cycle position and increment actions are dropped.
    assign w_req = w_sw2_req & ~r_evt[BTN_MODE];

`ifdef MODE_TIMEOUT_EN
    localparam int TW = $clog2(TIMEOUT + 1);
    localparam logic [TW-1:0] TO_LAST = TW'(TIMEOUT - 1);

    logic [TW-1:0] r_idle_cnt;
    logic          w_in_edit;

    assign w_in_edit = (r_mode == MODE_SETUP) | (r_mode == MODE_ALARM);
    assign w_timeout = w_in_edit & ~(|r_evt) & (r_idle_cnt == TO_LAST);

    // Idle counter for SETUP/ALARM; any button event or leaving/entering edit modes restarts it.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_idle_cnt <= '0;
        end else if (!w_in_edit || (|r_evt) || w_timeout) begin
            r_idle_cnt <= '0;
        end else begin
            r_idle_cnt <= r_idle_cnt + 1'b1;
        end
    end
`else
    // TIMEOUT only matters when the idle return is built in.
    assign w_timeout = 1'b0 && (TIMEOUT > 0);
`endif

    // State register for mode, position, alarm arm and the enable pulses.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_mode     <= MODE_CLOCK;
            r_pos      <= 1'b0;
            r_alm      <= 1'b0;
            r_sec_inc  <= 1'b0;
            r_min_inc  <= 1'b0;
            r_asec_inc <= 1'b0;
            r_amin_inc <= 1'b0;
        end else begin
            r_mode     <= w_mode_nx;
            r_pos      <= w_pos_nx;
            r_alm      <= w_alm_nx;
            r_sec_inc  <= w_sec_nx;
            r_min_inc  <= w_min_nx;
            r_asec_inc <= w_asec_nx;
            r_amin_inc <= w_amin_nx;
        end
    end

    // Next mode/position and the enable each mode routes the tick, wrap and sw2 request to.
    always_comb begin
        w_mode_nx = r_mode;
        w_pos_nx  = r_pos;
        w_alm_nx  = r_alm ^ r_evt[BTN_ALM];
        w_sec_nx  = 1'b0;
        w_min_nx  = 1'b0;
        w_asec_nx = 1'b0;
        w_amin_nx = 1'b0;
        case (r_mode)
            MODE_SETUP: begin
                // Time frozen; sw2 edits the selected time field.
                w_sec_nx = w_req & ~r_pos;
                w_min_nx = w_req &  r_pos;
                if (r_evt[BTN_MODE]) begin
                    w_mode_nx = MODE_ALARM;
                    w_pos_nx  = 1'b0;
                end else if (w_timeout) begin
                    w_mode_nx = MODE_CLOCK;
                    w_pos_nx  = 1'b0;
                end else if (r_evt[BTN_POS]) begin
                    w_pos_nx = ~r_pos;
                end
            end
            MODE_ALARM: begin
                // Time keeps running; sw2 edits the alarm field.
                w_sec_nx  = i_tick_1hz;
                w_min_nx  = i_sec_wrap;
                w_asec_nx = w_req & ~r_pos;
                w_amin_nx = w_req &  r_pos;
                if (r_evt[BTN_MODE]) begin
                    w_mode_nx = MODE_CLOCK;
                    w_pos_nx  = 1'b0;
                end else if (w_timeout) begin
                    w_mode_nx = MODE_CLOCK;
                    w_pos_nx  = 1'b0;
                end else if (r_evt[BTN_POS]) begin
                    w_pos_nx = ~r_pos;
                end
            end
            default: begin
                // CLOCK, and the unreachable code 11 treated as CLOCK; sw1 and sw2 ignored.
                w_sec_nx = i_tick_1hz;
                w_min_nx = i_sec_wrap;
                if (r_evt[BTN_MODE]) begin
                    w_mode_nx = MODE_SETUP;
                    w_pos_nx  = 1'b0;
                end
            end
        endcase
    end

    assign o_mode        = r_mode;
    assign o_position    = r_pos;
    assign o_alarm_en    = r_alm;
    assign o_sec_inc     = r_sec_inc;
    assign o_min_inc     = r_min_inc;
    assign o_alm_sec_inc = r_asec_inc;
    assign o_alm_min_inc = r_amin_inc;

endmodule

// File: tb/tb_clock_mode_fsm.sv
// tb_clock_mode_fsm: directed and random button/tick stimulus for clock_mode_fsm, scored against a reference model.
// Latency: expected outputs are queued one edge ahead and compared 1 time unit after each rising edge.
// Backpressure: none; the monitor skips cycles with no queued expectation (reset).
module tb_clock_mode_fsm;

    localparam int DEB = 4;
    localparam int DLY = 20;
    localparam int PER = 5;
    localparam int TO  = 100;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       i_sw0 = 1'b1, i_sw1 = 1'b1, i_sw2 = 1'b1, i_sw3 = 1'b1;
    logic       i_tick_1hz = 1'b0, i_sec_wrap = 1'b0;
    logic [1:0] o_mode;
    logic       o_position, o_alarm_en, o_sec_inc, o_min_inc, o_alm_sec_inc, o_alm_min_inc;

    always #5 clk = ~clk;

    clock_mode_fsm #(
        .DEB_CYCLES(DEB),
        .REPEAT_DLY(DLY),
        .REPEAT_PER(PER),
        .TIMEOUT   (TO)
    ) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .i_sw0        (i_sw0),
        .i_sw1        (i_sw1),
        .i_sw2        (i_sw2),
        .i_sw3        (i_sw3),
        .i_tick_1hz   (i_tick_1hz),
        .i_sec_wrap   (i_sec_wrap),
        .o_mode       (o_mode),
        .o_position   (o_position),
        .o_alarm_en   (o_alarm_en),
        .o_sec_inc    (o_sec_inc),
        .o_min_inc    (o_min_inc),
        .o_alm_sec_inc(o_alm_sec_inc),
        .o_alm_min_inc(o_alm_min_inc)
    );

    int n_tests = 0;
    int n_fail  = 0;
    logic [7:0] exp_q[$];

    // Reference model: raw sample history per button, accepted levels, events and plain-integer mode state.
    bit rh[4][0:7];
    bit m_deb[4];
    bit m_ev[4];
    int m_cyc;
    int m_t2;
    int m_mode;
    bit m_pos;
    bit m_alm;
    int m_last_clr;

    int pulse_min, pulse_sec, pulse_any;

    function automatic void model_reset();
        for (int b = 0; b < 4; b++) begin
            for (int k = 0; k < 8; k++) rh[b][k] = 1'b1;
            m_deb[b] = 1'b1;
            m_ev[b]  = 1'b0;
        end
        m_cyc      = 0;
        m_t2       = -100000;
        m_mode     = 0;
        m_pos      = 1'b0;
        m_alm      = 1'b0;
        m_last_clr = 0;
    endfunction

    // One rising edge of the model; sw/tick/wrap are the values the DUT samples at that edge.
    function automatic void model_edge(input bit [3:0] sw, input bit tick, input bit wrap);
        int m;
        int d;
        bit req, any_ev, tmo, all_diff;
        bit e_sec, e_min, e_asec, e_amin;
        m = m_cyc + 1;
        m_cyc = m;
        d = (m - 1) - m_t2;
        req = !m_deb[2] && d >= 0 && (d == 0 || (d >= DLY && ((d - DLY) % PER) == 0));
        any_ev = m_ev[0] | m_ev[1] | m_ev[2] | m_ev[3];
        tmo = 1'b0;
`ifdef MODE_TIMEOUT_EN
        if (any_ev || m_mode == 0) begin
            m_last_clr = m;
        end else if (m - m_last_clr == TO) begin
            tmo = 1'b1;
            m_last_clr = m;
        end
`endif
        if (m_ev[0]) req = 1'b0;
        e_sec  = (m_mode != 1 && tick) || (m_mode == 1 && req && !m_pos);
        e_min  = (m_mode != 1 && wrap) || (m_mode == 1 && req &&  m_pos);
        e_asec = (m_mode == 2 && req && !m_pos);
        e_amin = (m_mode == 2 && req &&  m_pos);
        if (m_ev[0]) begin
            m_mode = (m_mode + 1) % 3;
            m_pos  = 1'b0;
        end else if (tmo) begin
            m_mode = 0;
            m_pos  = 1'b0;
        end else if (m_ev[1] && m_mode != 0) begin
            m_pos = !m_pos;
        end
        if (m_ev[3]) m_alm = !m_alm;
        exp_q.push_back({2'(m_mode), m_pos, m_alm, e_sec, e_min, e_asec, e_amin});
        // A level is accepted once the last DEB samples, seen through the 2-cycle synchroniser, all differ from it.
        for (int b = 0; b < 4; b++) begin
            for (int k = 7; k > 0; k--) rh[b][k] = rh[b][k-1];
            rh[b][0] = sw[b];
            m_ev[b] = 1'b0;
            all_diff = 1'b1;
            for (int j = 0; j < DEB; j++) if (rh[b][2+j] == m_deb[b]) all_diff = 1'b0;
            if (all_diff) begin
                m_deb[b] = !m_deb[b];
                m_ev[b]  = !m_deb[b];
                if (b == 2 && m_ev[b]) m_t2 = m;
            end
        end
    endfunction

    task automatic chk(input string name, input logic [7:0] got, input logic [7:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, got, exp);
        end
    endtask

    task automatic step(input bit [3:0] sw, input bit tick, input bit wrap);
        @(negedge clk);
        pulse_min += int'(o_min_inc);
        pulse_sec += int'(o_sec_inc);
        pulse_any += int'(o_sec_inc | o_min_inc | o_alm_sec_inc | o_alm_min_inc);
        {i_sw3, i_sw2, i_sw1, i_sw0} = sw;
        i_tick_1hz = tick;
        i_sec_wrap = wrap;
        model_edge(sw, tick, wrap);
    endtask

    task automatic hold(input bit [3:0] sw, input int n);
        for (int i = 0; i < n; i++) step(sw, 1'b0, 1'b0);
    endtask

    task automatic press(input bit [3:0] sw);
        hold(sw, 10);
        hold(4'b1111, 10);
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst_n = 1'b0;
        {i_sw3, i_sw2, i_sw1, i_sw0} = 4'b1111;
        i_tick_1hz = 1'b0;
        i_sec_wrap = 1'b0;
        #1;
        chk("rst_mode",     8'(o_mode),        8'd0);
        chk("rst_position", 8'(o_position),    8'd0);
        chk("rst_alarm_en", 8'(o_alarm_en),    8'd0);
        chk("rst_sec_inc",  8'(o_sec_inc),     8'd0);
        chk("rst_min_inc",  8'(o_min_inc),     8'd0);
        chk("rst_alm_sec",  8'(o_alm_sec_inc), 8'd0);
        chk("rst_alm_min",  8'(o_alm_min_inc), 8'd0);
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        model_reset();
    endtask

    // Monitor: compare the DUT against the queued expectation just after each rising edge.
    initial begin
        logic [7:0] e, a;
        forever begin
            @(posedge clk);
            #1;
            if (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                a = {o_mode, o_position, o_alarm_en, o_sec_inc, o_min_inc, o_alm_sec_inc, o_alm_min_inc};
                n_tests++;
                if (a !== e) begin
                    n_fail++;
                    $display("FAIL scoreboard @%0t: got %b expected %b (mode,pos,alm,sec,min,asec,amin)", $time, a, e);
                end
            end
        end
    end

    // Stimulus
    initial begin
        bit [3:0] lvl;
        int       run[4];
        model_reset();
        pulse_min = 0; pulse_sec = 0; pulse_any = 0;
        do_reset();

        // Short bounce on sw0 must not register.
        hold(4'b1110, 3);
        hold(4'b1111, 12);
        chk("bounce_mode", 8'(o_mode), 8'd0);

        // Clean press: mode changes on the 7th edge after the raw edge.
        hold(4'b1110, 7);
        chk("press_not_yet", 8'(o_mode), 8'd0);
        hold(4'b1110, 1);
        chk("press_latency", 8'(o_mode), 8'd1);
        hold(4'b1110, 2);
        hold(4'b1111, 10);
        press(4'b1110);
        chk("mode_alarm", 8'(o_mode), 8'd2);
        press(4'b1110);
        chk("mode_clock", 8'(o_mode), 8'd0);

        // sw1 ignored in CLOCK; sw3 toggles alarm arm.
        press(4'b1101);
        chk("clock_pos_ignored", 8'(o_position), 8'd0);
        press(4'b0111);
        chk("alarm_en_on", 8'(o_alarm_en), 8'd1);

        // SETUP, position MIN, sw2 held 40 cycles: 5 minute pulses, no second pulses.
        press(4'b1110);
        press(4'b1101);
        chk("setup_pos_min", 8'(o_position), 8'd1);
        pulse_min = 0; pulse_sec = 0;
        hold(4'b1011, 40);
        hold(4'b1111, 15);
        chk("repeat_min_pulses", 8'(pulse_min), 8'd5);
        chk("repeat_sec_pulses", 8'(pulse_sec), 8'd0);
        press(4'b1110);
        chk("alarm_pos_cleared", 8'(o_position), 8'd0);
        press(4'b1110);

        // Tick and wrap together in CLOCK.
        step(4'b1111, 1'b1, 1'b1);
        step(4'b1111, 1'b0, 1'b0);
        chk("tickwrap_sec", 8'(o_sec_inc), 8'd1);
        chk("tickwrap_min", 8'(o_min_inc), 8'd1);
        step(4'b1111, 1'b0, 1'b0);
        chk("tickwrap_sec_width", 8'(o_sec_inc), 8'd0);
        chk("tickwrap_min_width", 8'(o_min_inc), 8'd0);

        // SETUP with sw0 and sw2 events in the same cycle: mode steps, increment dropped.
        press(4'b1110);
        pulse_any = 0;
        press(4'b1010);
        chk("sw0_sw2_mode", 8'(o_mode), 8'd2);
        chk("sw0_sw2_no_inc", 8'(pulse_any), 8'd0);
        press(4'b1110);

        // Random buttons (including bounces), ticks and wraps.
        lvl = 4'b1111;
        for (int b = 0; b < 4; b++) run[b] = $urandom_range(5, 80);
        for (int c = 0; c < 4000; c++) begin
            for (int b = 0; b < 4; b++) begin
                run[b]--;
                if (run[b] <= 0) begin
                    lvl[b] = !lvl[b];
                    run[b] = lvl[b] ? $urandom_range(1, 80) : $urandom_range(1, 50);
                end
            end
            step(lvl, ($urandom_range(0, 7) == 0), ($urandom_range(0, 15) == 0));
        end
        hold(4'b1111, 12);

`ifdef MODE_TIMEOUT_EN
        // Idle in SETUP returns to CLOCK after TIMEOUT cycles.
        do_reset();
        hold(4'b1110, 10);
        hold(4'b1111, 80);
        chk("timeout_not_early", 8'(o_mode), 8'd1);
        hold(4'b1111, 20);
        chk("timeout_to_clock", 8'(o_mode), 8'd0);
`endif

        // Reset asserted while sw2 is auto-repeating in SETUP.
        do_reset();
        press(4'b1110);
        press(4'b0111);
        hold(4'b1011, 35);
        do_reset();
        hold(4'b1111, 5);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
